// File: rtl/adder_pkg.sv
// Purpose : shared constants and state encoding for the adder datapath blocks.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

    // Default widths of the upstream adder sum and of the accumulator.
    localparam int DEFAULT_DATA_W = 5;
    localparam int DEFAULT_ACC_W  = 8;

    // Sum counter width; large enough for up to 15 sums per result.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage : adder_pkg

// File: rtl/sum_accumulator.sv
// Purpose : accumulates NUM_SUMS upstream adder sums into one ACC_W-bit total with sticky wrap flag.
// Latency : out_valid rises the cycle after the accept that completes the set.
// Backpressure: in_ready drops while a result is held; the result is held until out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_sum/in_valid/in_ready    sum input handshake (in_ready low while holding or clearing)
//   clear                synchronous abort, wins over accept and out_ready
//   out_total/out_ovf/out_valid/out_ready   result handshake; total and flag read 0 in IDLE
//   busy                 high whenever not IDLE
module sum_accumulator
    import adder_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_SUMS = 4,
    parameter int ACC_W    = DEFAULT_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  out_total,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    acc_state_t        r_state, w_state_nxt;
    logic [ACC_W-1:0]  r_acc,   w_acc_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_ovf,   w_ovf_nxt;

    logic              w_accept;
    logic [ACC_W:0]    w_add;      // extra MSB captures the carry out of the accumulator
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last;

    assign in_ready  = !clear && (r_state != HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_add     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(in_sum);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(NUM_SUMS));

    assign out_total = r_acc;
    assign out_ovf   = r_ovf;
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;

        if (clear) begin
            // Abort wins over everything; any sum offered this cycle is dropped
            // because in_ready is already low.
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_acc_nxt   = ACC_W'(in_sum);
                        w_cnt_nxt   = CNT_W'(1);
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = (NUM_SUMS == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        w_acc_nxt = w_add[ACC_W-1:0];
                        w_ovf_nxt = r_ovf | w_add[ACC_W];
                        w_cnt_nxt = w_cnt_inc;
                        if (w_last) begin
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule : sum_accumulator
